z16_multicycle_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle Z16 CPU top.
- Executes the Z16 16-bit instruction format over a generic DATA_W datapath.
- Accesses instruction and data memory through req/ack handshakes instead of combinational memories, so wait-stated SRAM or bus bridges can be attached.
- An FSM sequences FETCH/DECODE/EXEC/MEM/WB and adds branches, jumps and HALT.

---
 rtl/z16_multicycle_core.sv | 152 +++++++++++++++
 tb/tb_z16_multicycle_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/z16_multicycle_core.sv
// z16_multicycle_core: multi-cycle Z16 CPU with req/ack instruction and data memory ports.
// Optional Z16_ILLEGAL_TRAP_EN: opcodes D/E halt with o_trap instead of acting as NOPs.
module z16_multicycle_core #(
  parameter int DATA_W = 16,
  parameter int NREGS = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [DATA_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [15:0]       i_imem_rdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_halt,
  output logic              o_trap
);
  localparam int RW = NREGS > 1 ? $clog2(NREGS) : 1;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;
  logic [15:0] ir;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] pc, pc2, a, b, d, res, alu, imm4, imm8, immd;
  logic [3:0] op;
  logic [RW-1:0] rd, rs1, rs2;
  logic taken;
  assign op = ir[3:0];
  assign rd = ir[4 +: RW];
  assign rs1 = ir[8 +: RW];
  assign rs2 = ir[12 +: RW];
  assign imm4 = {{(DATA_W-4){ir[15]}}, ir[15:12]};
  assign imm8 = {{(DATA_W-8){ir[15]}}, ir[15:8]};
  assign immd = {{(DATA_W-4){ir[7]}}, ir[7:4]};
  assign pc2 = pc + DATA_W'(2);
  assign taken = op == 4'hA ? a == b : a != b;
  assign o_pc = pc;
  assign o_imem_addr = pc;
  always_comb begin
    alu = '0;
    case (op)
      4'h0: alu = a + b;
      4'h1: alu = a - b;
      4'h2: alu = a & b;
      4'h3: alu = a | b;
      4'h4: alu = a ^ b;
      4'h5: alu = a << b[3:0];
      4'h6: alu = $signed(a) >>> b[3:0];
      4'h7: alu = d + imm8;
      4'hC: alu = pc2;
      default: alu = '0;
    endcase
  end
`ifdef Z16_ILLEGAL_TRAP_EN
  logic trap;
  assign o_trap = trap;
`else
  assign o_trap = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      o_imem_req <= 1'b0;
      o_dmem_req <= 1'b0;
      o_dmem_we <= 1'b0;
      o_halt <= 1'b0;
`ifdef Z16_ILLEGAL_TRAP_EN
      trap <= 1'b0;
`endif
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          // req is armed on entry to FETCH; only the first fetch after reset raises it here
          if (!o_imem_req) o_imem_req <= 1'b1;
          else if (i_imem_ack) begin
            ir <= i_imem_rdata;
            o_imem_req <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          a <= rf[rs1];
          b <= rf[rs2];
          d <= rf[rd];
          state <= EXEC;
        end
        EXEC: begin
          res <= alu;
          case (op)
            4'h8, 4'h9: begin
              o_dmem_addr <= a + (op == 4'h8 ? imm4 : immd);
              o_dmem_we <= op == 4'h9;
              o_dmem_wdata <= b;
              o_dmem_req <= 1'b1;
              state <= MEM;
            end
            4'hA, 4'hB: begin
              pc <= taken ? pc + (immd << 1) : pc2;
              o_imem_req <= 1'b1;
              state <= FETCH;
            end
            4'hD, 4'hE: begin
`ifdef Z16_ILLEGAL_TRAP_EN
              o_halt <= 1'b1;
              trap <= 1'b1;
              state <= HALT;
`else
              pc <= pc2;
              o_imem_req <= 1'b1;
              state <= FETCH;
`endif
            end
            4'hF: begin
              pc <= pc2;
              o_halt <= 1'b1;
              state <= HALT;
            end
            default: state <= WB;
          endcase
        end
        MEM: begin
          if (i_dmem_ack) begin
            o_dmem_req <= 1'b0;
            o_dmem_we <= 1'b0;
            if (o_dmem_we) begin
              pc <= pc2;
              o_imem_req <= 1'b1;
              state <= FETCH;
            end else begin
              res <= i_dmem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          if (rd != '0) rf[rd] <= res;
          pc <= op == 4'hC ? pc + (imm8 << 1) : pc2;
          o_imem_req <= 1'b1;
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_z16_multicycle_core.sv
// tb_z16_multicycle_core: scoreboard bench; expected fetch/data transactions are queued up front
// and a monitor pops them on every handshake, also checking per-instruction cycle gaps.
module tb_z16_multicycle_core;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, halt, trap;
  logic [15:0] imem_addr, imem_rdata = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, pc;
  logic [15:0] prog [128];
  logic [15:0] dm [256];
  int checks = 0, errors = 0, cyc = 0, last = 0, dlen = 0, iwait = 0, dwait = 2, icnt = 0, dcnt = 0;
  typedef struct {logic [15:0] a; int gap;} fexp_t;
  typedef struct {logic we; logic [15:0] a; logic [15:0] d;} dexp_t;
  fexp_t fq[$];
  dexp_t dq[$];

  z16_multicycle_core dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_pc(pc), .o_halt(halt), .o_trap(trap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pf(input logic [15:0] a, input int g);
    fq.push_back('{a, g});
  endtask

  task automatic pd(input logic we, input logic [15:0] a, input logic [15:0] d);
    dq.push_back('{we, a, d});
  endtask

  // memory responders: ack after iwait/dwait stall cycles
  initial forever begin
    @(negedge clk);
    if (imem_req && icnt >= iwait) begin
      imem_ack = 1;
      imem_rdata = prog[imem_addr[7:1]];
    end else begin
      imem_ack = 0;
      icnt = imem_req ? icnt + 1 : 0;
    end
    if (dmem_req && dcnt >= dwait) begin
      dmem_ack = 1;
      dmem_rdata = dm[dmem_addr[7:0]];
      if (dmem_we) dm[dmem_addr[7:0]] = dmem_wdata;
    end else begin
      dmem_ack = 0;
      dcnt = dmem_req ? dcnt + 1 : 0;
    end
  end

  initial forever begin
    fexp_t fe;
    dexp_t de;
    @(negedge clk);
    #1;
    if (rst) begin
      dlen = 0;
      continue;
    end
    if (dmem_req) dlen++;
    if (imem_req && imem_ack) begin
      if (fq.size() == 0) chk("fetch_unexpected", {16'h0, imem_addr}, 32'hFFFF_FFFF);
      else begin
        fe = fq.pop_front();
        chk("fetch_addr", {16'h0, imem_addr}, {16'h0, fe.a});
        if (fe.gap != 0) chk("fetch_gap", cyc - last, fe.gap);
      end
      last = cyc;
    end
    if (dmem_req && dmem_ack) begin
      if (dq.size() == 0) chk("dmem_unexpected", {16'h0, dmem_addr}, 32'hFFFF_FFFF);
      else begin
        de = dq.pop_front();
        chk("dmem_we", dmem_we, de.we);
        chk("dmem_addr", dmem_addr, de.a);
        if (de.we) chk("dmem_wdata", dmem_wdata, de.d);
        chk("dmem_req_len", dlen, dwait + 1);
      end
      dlen = 0;
    end
  end

  initial begin
    int seen;
    for (int i = 0; i < 128; i++) prog[i] = 16'h000F;
    for (int i = 0; i < 256; i++) dm[i] = 16'h0;
    dm[8'h20] = 16'hBEEF;
    {prog[0], prog[1], prog[2], prog[3], prog[4], prog[5], prog[6], prog[7]} =
      {16'h0517, 16'hFE17, 16'h1009, 16'h0847, 16'h0F17, 16'h4115, 16'h3417, 16'h1049};
    {prog[8], prog[9], prog[10], prog[13], prog[14], prog[15], prog[16], prog[17]} =
      {16'h4028, 16'h2069, 16'h003A, 16'h003B, 16'h002A, 16'h020C, 16'hFF3C, 16'h3029};
    {prog[18], prog[19], prog[20], prog[21], prog[22], prog[23], prog[24], prog[25]} =
      {16'h0309, 16'h1351, 16'h3164, 16'h4576, 16'h5182, 16'h3193, 16'h21A0, 16'h5009};
    {prog[26], prog[27], prog[28], prog[29], prog[30], prog[31], prog[32], prog[33], prog[34]} =
      {16'h6009, 16'h7009, 16'h8009, 16'h9009, 16'hA009, 16'hE3B8, 16'hB009, 16'h000D, 16'h000F};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_halt", halt, 0);
    chk("rst_trap", trap, 0);
    chk("rst_pc", pc, 0);
    pf(16'h00, 0); pf(16'h02, 4); pf(16'h04, 4); pf(16'h06, 6); pf(16'h08, 4); pf(16'h0A, 4);
    pf(16'h0C, 4); pf(16'h0E, 4); pf(16'h10, 6); pf(16'h12, 7); pf(16'h14, 6); pf(16'h1A, 3);
    pf(16'h1C, 3); pf(16'h20, 3); pf(16'h1E, 4); pf(16'h22, 4); pf(16'h24, 6); pf(16'h26, 6);
    for (int i = 0; i < 6; i++) pf(16'h28 + 16'(2 * i), 4);
    for (int i = 0; i < 6; i++) pf(16'h34 + 16'(2 * i), 6);
    pf(16'h40, 7); pf(16'h42, 6);
`ifndef Z16_ILLEGAL_TRAP_EN
    pf(16'h44, 3);
`endif
    pd(1, 16'h0, 16'h0003); pd(1, 16'h4, 16'h1234); pd(0, 16'h4, 0); pd(1, 16'h6, 16'h1234);
    pd(1, 16'h2, 16'h0022); pd(1, 16'h22, 16'h0000); pd(1, 16'h0, 16'hEDEE); pd(1, 16'h0, 16'h1216);
    pd(1, 16'h0, 16'hFFED); pd(1, 16'h0, 16'h0024); pd(1, 16'h0, 16'h1236); pd(1, 16'h0, 16'h2468);
    pd(0, 16'h20, 0); pd(1, 16'h0, 16'hBEEF);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 2000 && !halt; i++) @(negedge clk);
    chk("halt_reached", halt, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (imem_req || dmem_req) seen++;
    end
    chk("halt_no_req", seen, 0);
    chk("fetch_queue_drained", fq.size(), 0);
    chk("dmem_queue_drained", dq.size(), 0);
`ifdef Z16_ILLEGAL_TRAP_EN
    chk("trap_set", trap, 1);
    chk("trap_pc", pc, 16'h42);
`else
    chk("trap_clear", trap, 0);
`endif
    @(negedge clk);
    rst = 1;
    iwait = 5;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    chk("wait_fetch_req", imem_req, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_req", imem_req, 0);
    chk("rst_mid_pc", pc, 0);
    chk("rst_mid_halt", halt, 0);
    @(negedge clk);
    iwait = 0;
    pf(16'h00, 0);
    rst = 0;
    for (int i = 0; i < 50 && fq.size() != 0; i++) @(negedge clk);
    chk("refetch_done", fq.size(), 0);
    rst = 1;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
